// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline sequencing controller for a 5-stage RISC core. It drives the load
// enables, holds and flushes of the PC, IF/ID, ID/EX and EX/MEM registers.
// Three kinds of hazard are resolved:
//   * data-memory wait states (mem_busy freezes the whole pipe),
//   * EX-stage redirects (taken branch/jump flushes the younger stages),
//   * load-use dependencies (one bubble inserted into ID/EX).
// When the instruction memory is synchronous (FETCH_LAT=1), the fetch issued
// in the redirect cycle returns a wrong-path word one cycle later, so a
// second ("shadow") IF/ID flush follows every redirect.
//
// Control outputs are combinational from the state register, the internal
// registers and the current inputs. Statistics and the sticky timeout flag
// update on the clock.
//
// Ports
//   clk          in   1       clock, rising edge
//   rst          in   1       synchronous active-high reset
//   id_rs1       in   REG_AW  rs1 of the instruction in ID
//   id_rs2       in   REG_AW  rs2 of the instruction in ID
//   id_use_rs1   in   1       ID instruction reads rs1
//   id_use_rs2   in   1       ID instruction reads rs2
//   ex_rd        in   REG_AW  destination of the instruction in EX
//   ex_mem_read  in   1       EX instruction is a load
//   ex_redirect  in   1       taken branch/jump resolved in EX this cycle
//   mem_busy     in   1       data memory not ready, freeze the pipe
//   pc_write     out  1       PC load enable
//   if_id_write  out  1       IF/ID load enable
//   if_id_flush  out  1       IF/ID loads a NOP
//   id_ex_flush  out  1       ID/EX control fields zeroed (data still loads)
//   id_ex_hold   out  1       ID/EX keeps its contents
//   ex_mem_hold  out  1       EX/MEM keeps its contents
//   stall_count  out  CNT_W   saturating count of freeze/load-use cycles
//   flush_count  out  CNT_W   saturating count of redirect events
//   timeout_err  out  1       sticky, mem_busy lasted TIMEOUT cycles
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int REG_AW    = 5,
    parameter int CNT_W     = 16,
    parameter int FETCH_LAT = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_redirect,
    input  logic              mem_busy,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              id_ex_hold,
    output logic              ex_mem_hold,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count,
    output logic              timeout_err
);

    // busy_cnt only needs to reach TIMEOUT; it saturates there.
    localparam int                BUSY_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [BUSY_W-1:0] BUSY_LIMIT = BUSY_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    // FREEZE is a condition rather than a state: it leaves state_q untouched.
    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SHADOW = 1'b1
    } state_t;

    state_t             state_q,       state_d;
    logic [BUSY_W-1:0]  busy_cnt_q,    busy_cnt_d;
    logic [CNT_W-1:0]   stall_count_q, stall_count_d;
    logic [CNT_W-1:0]   flush_count_q, flush_count_d;
    logic               timeout_err_q, timeout_err_d;

    logic load_use;
    logic freeze_act;
    logic redirect_act;
    logic shadow_act;
    logic load_use_act;

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [BUSY_W-1:0] busy_sat_inc(input logic [BUSY_W-1:0] v);
        return (v >= BUSY_LIMIT) ? BUSY_LIMIT : v + 1'b1;
    endfunction

    // Hazard detection. x0 is hardwired zero and never creates a dependency.
    always_comb begin
        load_use = ex_mem_read && (ex_rd != '0) &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                    (id_use_rs2 && (id_rs2 == ex_rd)));
    end

    // Priority: mem_busy > redirect > shadow > load_use > normal.
    // A load-use coinciding with a redirect is dropped: the ID instruction
    // is on the wrong path and gets flushed instead of stalled.
    always_comb begin
        freeze_act   = mem_busy;
        redirect_act = ex_redirect && !mem_busy;
        shadow_act   = (state_q == ST_SHADOW) && !mem_busy && !ex_redirect;
        load_use_act = load_use && !mem_busy && !ex_redirect && (state_q != ST_SHADOW);
    end

    // Pipeline register controls.
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        id_ex_hold  = 1'b0;
        ex_mem_hold = 1'b0;
        if (freeze_act) begin
            // EX is held, so any pending redirect is re-presented later.
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_hold  = 1'b1;
            ex_mem_hold = 1'b1;
        end else if (redirect_act) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (shadow_act) begin
            // ID already holds the NOP from the redirect cycle; only the
            // late-arriving wrong-path fetch needs squashing.
            if_id_flush = 1'b1;
        end else if (load_use_act) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    // Next-state, counters and sticky flag.
    always_comb begin
        state_d       = state_q;
        busy_cnt_d    = '0;
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        timeout_err_d = timeout_err_q;

        if (freeze_act) begin
            busy_cnt_d    = busy_sat_inc(busy_cnt_q);
            stall_count_d = cnt_sat_inc(stall_count_q);
            if (busy_cnt_d == BUSY_LIMIT) begin
                timeout_err_d = 1'b1;
            end
        end else if (redirect_act) begin
            flush_count_d = cnt_sat_inc(flush_count_q);
            // A redirect while in SHADOW keeps us in SHADOW for the new target.
            state_d       = (FETCH_LAT == 1) ? ST_SHADOW : ST_RUN;
        end else if (shadow_act) begin
            state_d       = ST_RUN;
        end else if (load_use_act) begin
            // The load leaves EX next cycle, so the stall never repeats.
            stall_count_d = cnt_sat_inc(stall_count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            busy_cnt_q    <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            busy_cnt_q    <= busy_cnt_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Self-checking bench for hazard_ctrl (REG_AW=5, CNT_W=2, FETCH_LAT=1,
// TIMEOUT=4). Directed sequences for reset, load-use, redirect with shadow
// flush, freeze over redirect, timeout, counter saturation and reset during
// the shadow cycle are followed by randomized traffic. A behavioural model
// tracks "shadow flush owed", the current busy run length, the two event
// totals and the sticky error, and predicts every cycle's controls.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int REG_AW    = 5;
    localparam int CNT_W     = 2;
    localparam int FETCH_LAT = 1;
    localparam int TIMEOUT   = 4;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
    logic              id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect, mem_busy;
    logic              pc_write, if_id_write, if_id_flush, id_ex_flush;
    logic              id_ex_hold, ex_mem_hold, timeout_err;
    logic [CNT_W-1:0]  stall_count, flush_count;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    bit m_shadow;
    int m_busy_run;
    int m_stalls;
    int m_flushes;
    bit m_err;

    hazard_ctrl #(
        .REG_AW   (REG_AW),
        .CNT_W    (CNT_W),
        .FETCH_LAT(FETCH_LAT),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_rd      (ex_rd),
        .ex_mem_read(ex_mem_read),
        .ex_redirect(ex_redirect),
        .mem_busy   (mem_busy),
        .pc_write   (pc_write),
        .if_id_write(if_id_write),
        .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush),
        .id_ex_hold (id_ex_hold),
        .ex_mem_hold(ex_mem_hold),
        .stall_count(stall_count),
        .flush_count(flush_count),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_shadow   = 1'b0;
        m_busy_run = 0;
        m_stalls   = 0;
        m_flushes  = 0;
        m_err      = 1'b0;
    endtask

    // One clock cycle: apply inputs, check the controls and counters in the
    // middle of the cycle, then advance the model across the rising edge.
    task automatic cycle(input bit r, input bit busy, input bit redir,
                         input bit mr, input logic [REG_AW-1:0] rd,
                         input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2,
                         input bit u1, input bit u2);
        bit         lu;
        logic [5:0] exp_ctl;
        rst = r; mem_busy = busy; ex_redirect = redir; ex_mem_read = mr;
        ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;

        lu = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        // {pc_write, if_id_write, if_id_flush, id_ex_flush, id_ex_hold, ex_mem_hold}
        if (busy)          exp_ctl = 6'b000011;
        else if (redir)    exp_ctl = 6'b111100;
        else if (m_shadow) exp_ctl = 6'b111000;
        else if (lu)       exp_ctl = 6'b000100;
        else               exp_ctl = 6'b110000;

        @(negedge clk);
        chk("ctl", {26'd0, pc_write, if_id_write, if_id_flush, id_ex_flush,
                    id_ex_hold, ex_mem_hold}, {26'd0, exp_ctl});
        chk("stall_count", 32'(stall_count), 32'(m_stalls));
        chk("flush_count", 32'(flush_count), 32'(m_flushes));
        chk("timeout_err", 32'(timeout_err), 32'(m_err));

        @(posedge clk);
        if (r) begin
            model_reset();
        end else if (busy) begin
            m_busy_run++;
            if (m_stalls < CNT_MAX) m_stalls++;
            if (m_busy_run >= TIMEOUT) m_err = 1'b1;
        end else begin
            m_busy_run = 0;
            if (redir) begin
                if (m_flushes < CNT_MAX) m_flushes++;
                m_shadow = (FETCH_LAT == 1);
            end else if (m_shadow) begin
                m_shadow = 1'b0;
            end else if (lu) begin
                if (m_stalls < CNT_MAX) m_stalls++;
            end
        end
        #1;
    endtask

    task automatic idle(input bit r);
        cycle(r, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit r, busy, redir, mr, u1, u2;
        int busy_left;
        rst = 1'b1; mem_busy = 0; ex_redirect = 0; ex_mem_read = 0;
        ex_rd = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Reset values
        idle(0);
        chk("rst_stall", 32'(stall_count), 32'd0);

        // Load-use on rs2, then the same with ex_rd = x0
        cycle(0, 0, 0, 1, 5, 0, 5, 0, 1);
        chk("lu_stall_cnt", 32'(stall_count), 32'd1);
        cycle(0, 0, 0, 1, 0, 0, 0, 0, 1);
        chk("lu_x0_cnt", 32'(stall_count), 32'd1);
        cycle(0, 0, 0, 1, 7, 7, 3, 1, 0);   // rs1 dependency

        // Redirect with shadow flush
        idle(1);
        cycle(0, 0, 1, 0, 0, 0, 0, 0, 0);
        idle(0);
        idle(0);
        chk("redir_flush_cnt", 32'(flush_count), 32'd1);

        // Freeze over redirect, then redirect once memory is ready
        idle(1);
        repeat (3) cycle(0, 1, 1, 0, 0, 0, 0, 0, 0);
        chk("freeze_stall_cnt", 32'(stall_count), 32'd3);
        cycle(0, 0, 1, 0, 0, 0, 0, 0, 0);
        idle(0);
        idle(0);
        chk("freeze_flush_cnt", 32'(flush_count), 32'd1);

        // Timeout: 3 busy cycles not enough, 4 sets it, it sticks until rst
        idle(1);
        repeat (3) cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(0);
        chk("timeout_early", 32'(timeout_err), 32'd0);
        repeat (4) cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("timeout_set", 32'(timeout_err), 32'd1);
        repeat (3) idle(0);
        idle(1);
        chk("timeout_clr", 32'(timeout_err), 32'd0);

        // Saturation: 5 load-use stalls on a 2-bit counter
        repeat (5) begin
            cycle(0, 0, 0, 1, 9, 9, 0, 1, 0);
            idle(0);
        end
        chk("stall_sat", 32'(stall_count), 32'd3);

        // Load-use coinciding with redirect: redirect wins
        cycle(0, 0, 1, 1, 4, 4, 4, 1, 1);
        idle(0);

        // Reset during the shadow cycle
        idle(1);
        cycle(0, 0, 1, 0, 0, 0, 0, 0, 0);
        idle(1);
        idle(0);

        // Randomized traffic
        busy_left = 0;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(99) < 2);
            if (busy_left == 0 && $urandom_range(99) < 12) busy_left = $urandom_range(7, 1);
            busy = (busy_left != 0);
            if (busy_left != 0) busy_left--;
            redir = ($urandom_range(99) < 15);
            mr    = $urandom_range(1);
            u1    = $urandom_range(1);
            u2    = $urandom_range(1);
            cycle(r, busy, redir, mr, REG_AW'($urandom_range(3)),
                  REG_AW'($urandom_range(3)), REG_AW'($urandom_range(3)), u1, u2);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
